// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer: channel state encoding and sizing constants.
package glitch_pkg;

   localparam int unsigned NCH_MAX       = 8;
   localparam int unsigned CNT_W_DEFAULT = 32;

   typedef enum logic [2:0] {
      CH_IDLE  = 3'd0,
      CH_ARMED = 3'd1,
      CH_DELAY = 3'd2,
      CH_PULSE = 3'd3,
      CH_GAP   = 3'd4,
      CH_DONE  = 3'd5
   } chan_state_e;

endpackage

// File: rtl/glitch_chan.sv
// One glitch channel: config snapshot, delay/pulse/gap counters and registered output level.
module glitch_chan
   import glitch_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             arm_go,
   input  logic             trig_go,
   input  logic [CNT_W-1:0] cfg_delay,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic             cfg_vstart,
   output logic             vout,
   output logic             done,
   output logic             done_nxt_c
);

   chan_state_e      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] left, left_n;
   logic [CNT_W-1:0] delay_q, width_q, gap_q, count_q;
   logic             vs_q, vs_n, vout_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CH_IDLE;
         cnt     <= '0;
         left    <= '0;
         delay_q <= '0;
         width_q <= '0;
         gap_q   <= '0;
         count_q <= '0;
         vs_q    <= 1'b0;
         vout    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         left  <= left_n;
         if (arm_go) begin
            delay_q <= cfg_delay;
            width_q <= cfg_width;
            gap_q   <= cfg_gap;
            count_q <= cfg_count;
            vs_q    <= cfg_vstart;
         end
         vout <= vout_n;
         done <= (state_n == CH_DONE);
      end
   end

   // cnt holds cycles remaining in the current phase minus one; left holds pulses still owed.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      left_n  = left;
      if (abort) begin
         state_n = CH_IDLE;
      end else begin
         case (state)
            CH_IDLE, CH_DONE: begin
               if (arm_go) state_n = CH_ARMED;
            end
            CH_ARMED: begin
               if (trig_go) begin
                  state_n = CH_DELAY;
                  cnt_n   = delay_q;
                  left_n  = (count_q == '0) ? '0 : count_q - CNT_W'(1);
               end
            end
            CH_DELAY: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CNT_W'(1);
               end else if (width_q == '0) begin
                  state_n = CH_DONE;
               end else begin
                  state_n = CH_PULSE;
                  cnt_n   = width_q - CNT_W'(1);
               end
            end
            CH_PULSE: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CNT_W'(1);
               end else if (left == '0) begin
                  state_n = CH_DONE;
               end else if (gap_q == '0) begin
                  cnt_n  = width_q - CNT_W'(1);
                  left_n = left - CNT_W'(1);
               end else begin
                  state_n = CH_GAP;
                  cnt_n   = gap_q - CNT_W'(1);
               end
            end
            CH_GAP: begin
               if (cnt != '0) begin
                  cnt_n = cnt - CNT_W'(1);
               end else begin
                  state_n = CH_PULSE;
                  cnt_n   = width_q - CNT_W'(1);
                  left_n  = left - CNT_W'(1);
               end
            end
            default: state_n = CH_IDLE;
         endcase
      end
   end

   // Idle channels follow the live level; once armed the snapshot level is used.
   always_comb begin
      vs_n   = (state_n == CH_IDLE || arm_go) ? cfg_vstart : vs_q;
      vout_n = (state_n == CH_PULSE) ? ~vs_n : vs_n;
   end

   assign done_nxt_c = (state_n == CH_DONE);

endmodule

// File: rtl/glitch_seq.sv
// Multi-channel glitch sequencer: trigger qualification, arm/abort control and aggregate flags.
// Define GLITCH_SEQ_TRIG_SYNC_EN to pass trigger_in through a 2-flop synchronizer first.
module glitch_seq
   import glitch_pkg::*;
#(
   parameter int unsigned NCH   = 2,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arm,
   input  logic                 abort,
   input  logic                 trigger_in,
   input  logic                 invert_trigger,
   input  logic [NCH*CNT_W-1:0] cfg_delay,
   input  logic [NCH*CNT_W-1:0] cfg_width,
   input  logic [NCH*CNT_W-1:0] cfg_gap,
   input  logic [NCH*CNT_W-1:0] cfg_count,
   input  logic [NCH-1:0]       cfg_vstart,
   output logic [NCH-1:0]       vout,
   output logic                 armed,
   output logic                 glitched,
   output logic                 finished,
   output logic [NCH-1:0]       ch_done
);

   logic           trig_s, trig_p;
   logic           edge_c, arm_go_c, trig_go_c;
   logic [NCH-1:0] done_nxt_c;

`ifdef GLITCH_SEQ_TRIG_SYNC_EN
   logic trig_meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         trig_meta <= 1'b0;
         trig_s    <= 1'b0;
      end else begin
         trig_meta <= trigger_in;
         trig_s    <= trig_meta;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) trig_s <= 1'b0;
      else     trig_s <= trigger_in;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) trig_p <= 1'b0;
      else     trig_p <= trig_s;
   end

   // Arm is only accepted with no sequence in flight; abort dominates arm and trigger.
   assign edge_c    = (trig_s ^ invert_trigger) & ~(trig_p ^ invert_trigger);
   assign arm_go_c  = arm & ~abort & ~armed & ~glitched;
   assign trig_go_c = edge_c & armed & ~abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         armed    <= 1'b0;
         glitched <= 1'b0;
         finished <= 1'b0;
      end else begin
         if (abort)          armed <= 1'b0;
         else if (arm_go_c)  armed <= 1'b1;
         else if (trig_go_c) armed <= 1'b0;

         if (abort)            glitched <= 1'b0;
         else if (trig_go_c)   glitched <= 1'b1;
         else if (&done_nxt_c) glitched <= 1'b0;

         finished <= &done_nxt_c;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      glitch_chan #(.CNT_W(CNT_W)) u_chan (
         .clk        (clk),
         .rst        (rst),
         .abort      (abort),
         .arm_go     (arm_go_c),
         .trig_go    (trig_go_c),
         .cfg_delay  (cfg_delay[i*CNT_W +: CNT_W]),
         .cfg_width  (cfg_width[i*CNT_W +: CNT_W]),
         .cfg_gap    (cfg_gap[i*CNT_W +: CNT_W]),
         .cfg_count  (cfg_count[i*CNT_W +: CNT_W]),
         .cfg_vstart (cfg_vstart[i]),
         .vout       (vout[i]),
         .done       (ch_done[i]),
         .done_nxt_c (done_nxt_c[i])
      );
   end

endmodule

// File: tb/tb_glitch_seq.sv
// Directed self-checking bench for glitch_seq (NCH=2, CNT_W=32); follows GLITCH_SEQ_TRIG_SYNC_EN.
module tb_glitch_seq;

   localparam int unsigned NCH   = 2;
   localparam int unsigned CNT_W = 32;
`ifdef GLITCH_SEQ_TRIG_SYNC_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic                 clk = 1'b0;
   logic                 rst, arm, abort, trigger_in, invert_trigger;
   logic [NCH*CNT_W-1:0] cfg_delay, cfg_width, cfg_gap, cfg_count;
   logic [NCH-1:0]       cfg_vstart;
   logic [NCH-1:0]       vout, ch_done;
   logic                 armed, glitched, finished;

   int n_tests = 0;
   int n_fail  = 0;

   glitch_seq #(.NCH(NCH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .arm            (arm),
      .abort          (abort),
      .trigger_in     (trigger_in),
      .invert_trigger (invert_trigger),
      .cfg_delay      (cfg_delay),
      .cfg_width      (cfg_width),
      .cfg_gap        (cfg_gap),
      .cfg_count      (cfg_count),
      .cfg_vstart     (cfg_vstart),
      .vout           (vout),
      .armed          (armed),
      .glitched       (glitched),
      .finished       (finished),
      .ch_done        (ch_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [31:0] d, input logic [31:0] w,
                         input logic [31:0] g, input logic [31:0] c);
      cfg_delay[ch*CNT_W +: CNT_W] = d;
      cfg_width[ch*CNT_W +: CNT_W] = w;
      cfg_gap[ch*CNT_W +: CNT_W]   = g;
      cfg_count[ch*CNT_W +: CNT_W] = c;
   endtask

   task automatic prep(input logic idle_lvl);
      abort = 1'b1;
      step();
      abort = 1'b0;
      trigger_in = idle_lvl;
      repeat (3) step();
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   // Drive the trigger level and advance to just after detect edge E.
   task automatic fire(input logic lvl);
      trigger_in = lvl;
      repeat (LAT + 1) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_vstart = 2'b10;
      repeat (3) step();
      n_tests++;
      if ({vout, armed, glitched, finished, ch_done} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0000000", {vout, armed, glitched, finished, ch_done});
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (vout !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_vstart: got %b want 10", vout);
      end
      cfg_vstart = 2'b00;
      step();
   endtask

   task automatic test_basic();
      logic exp_v, exp_f;
      set_ch(0, 3, 2, 0, 1);
      set_ch(1, 0, 0, 0, 0);
      prep(1'b0);
      do_arm();
      n_tests++;
      if (armed !== 1'b1 || finished !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_arm: got armed=%b finished=%b want 1 0", armed, finished);
      end
      fire(1'b1);
      n_tests++;
      if (armed !== 1'b0 || glitched !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_edge: got armed=%b glitched=%b want 0 1", armed, glitched);
      end
      for (int j = 1; j <= 7; j++) begin
         step();
         exp_v = (j == 4 || j == 5);
         exp_f = (j >= 6);
         n_tests++;
         if (vout[0] !== exp_v || finished !== exp_f || glitched !== !exp_f) begin
            n_fail++;
            $display("FAIL basic_E+%0d: got vout0=%b fin=%b gl=%b want %b %b %b",
                     j, vout[0], finished, glitched, exp_v, exp_f, !exp_f);
         end
         if (j == 1) begin
            n_tests++;
            if (ch_done[1] !== 1'b1 || vout[1] !== 1'b0) begin
               n_fail++;
               $display("FAIL basic_ch1_done: got done=%b vout=%b want 1 0", ch_done[1], vout[1]);
            end
         end
      end
   endtask

   task automatic test_pulse_train();
      logic exp_v;
      set_ch(0, 0, 1, 2, 3);
      prep(1'b0);
      do_arm();
      fire(1'b1);
      for (int j = 1; j <= 8; j++) begin
         step();
         exp_v = (j == 1 || j == 4 || j == 7);
         n_tests++;
         if (vout[0] !== exp_v || ch_done[0] !== (j == 8)) begin
            n_fail++;
            $display("FAIL train_E+%0d: got vout0=%b done0=%b want %b %b",
                     j, vout[0], ch_done[0], exp_v, (j == 8));
         end
      end
   endtask

   task automatic test_merge_count0();
      logic [1:0] exp_v;
      set_ch(0, 0, 2, 0, 2);
      set_ch(1, 2, 1, 5, 0);
      prep(1'b0);
      do_arm();
      fire(1'b1);
      for (int j = 1; j <= 6; j++) begin
         step();
         exp_v = {(j == 3), (j <= 4)};
         n_tests++;
         if (vout !== exp_v || finished !== (j >= 5)) begin
            n_fail++;
            $display("FAIL merge_E+%0d: got vout=%b fin=%b want %b %b",
                     j, vout, finished, exp_v, (j >= 5));
         end
      end
   endtask

   task automatic test_invert();
      set_ch(0, 1, 1, 0, 1);
      set_ch(1, 0, 0, 0, 0);
      cfg_vstart = 2'b01;
      invert_trigger = 1'b1;
      prep(1'b0);
      do_arm();
      trigger_in = 1'b1;
      repeat (4) step();
      n_tests++;
      if (armed !== 1'b1 || glitched !== 1'b0 || vout[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL invert_rise_ignored: got armed=%b gl=%b vout0=%b want 1 0 1", armed, glitched, vout[0]);
      end
      fire(1'b0);
      n_tests++;
      if (armed !== 1'b0 || glitched !== 1'b1) begin
         n_fail++;
         $display("FAIL invert_fall_edge: got armed=%b gl=%b want 0 1", armed, glitched);
      end
      for (int j = 1; j <= 3; j++) begin
         step();
         n_tests++;
         if (vout !== ((j == 2) ? 2'b00 : 2'b01) || finished !== (j >= 3)) begin
            n_fail++;
            $display("FAIL invert_E+%0d: got vout=%b fin=%b want %b %b",
                     j, vout, finished, ((j == 2) ? 2'b00 : 2'b01), (j >= 3));
         end
      end
      invert_trigger = 1'b0;
      cfg_vstart = 2'b00;
   endtask

   task automatic test_abort();
      set_ch(0, 0, 5, 0, 1);
      prep(1'b0);
      do_arm();
      fire(1'b1);
      repeat (2) step();
      n_tests++;
      if (vout[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_pre_pulse: got %b want 1", vout[0]);
      end
      abort = 1'b1;
      arm = 1'b1;
      step();
      abort = 1'b0;
      arm = 1'b0;
      n_tests++;
      if (vout !== 2'b00 || armed !== 1'b0 || glitched !== 1'b0 || finished !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: got vout=%b armed=%b gl=%b fin=%b want 00 0 0 0",
                  vout, armed, glitched, finished);
      end
      set_ch(0, 0, 1, 0, 1);
      prep(1'b0);
      do_arm();
      fire(1'b1);
      step();
      n_tests++;
      if (vout[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_rearm_pulse: got %b want 1", vout[0]);
      end
      step();
      n_tests++;
      if (vout[0] !== 1'b0 || finished !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_rearm_done: got vout0=%b fin=%b want 0 1", vout[0], finished);
      end
   endtask

   task automatic test_cfg_hold();
      set_ch(0, 3, 1, 0, 1);
      prep(1'b0);
      do_arm();
      set_ch(0, 10, 4, 0, 1);
      fire(1'b1);
      for (int j = 1; j <= 10; j++) begin
         step();
         n_tests++;
         if (vout[0] !== (j == 4) || finished !== (j >= 5) || armed !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_E+%0d: got vout0=%b fin=%b armed=%b want %b %b 0",
                     j, vout[0], finished, armed, (j == 4), (j >= 5));
         end
         if (j == 1) trigger_in = 1'b0;
         if (j == 2) begin
            trigger_in = 1'b1;
            arm = 1'b1;
         end
         if (j == 3) arm = 1'b0;
      end
   endtask

   task automatic test_rst_mid_gap();
      cfg_vstart = 2'b11;
      set_ch(0, 0, 1, 3, 2);
      prep(1'b0);
      do_arm();
      fire(1'b1);
      step();
      n_tests++;
      if (vout !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_gap_pulse: got %b want 10", vout);
      end
      step();
      n_tests++;
      if (vout !== 2'b11 || glitched !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_gap_idle: got vout=%b gl=%b want 11 1", vout, glitched);
      end
      rst = 1'b1;
      step();
      n_tests++;
      if ({vout, armed, glitched, finished, ch_done} !== 7'b0) begin
         n_fail++;
         $display("FAIL rst_gap_cleared: got %b want 0000000", {vout, armed, glitched, finished, ch_done});
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (vout !== 2'b11 || ch_done !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_gap_release: got vout=%b done=%b want 11 00", vout, ch_done);
      end
      cfg_vstart = 2'b00;
   endtask

   initial begin
      rst = 1'b1;
      arm = 1'b0;
      abort = 1'b0;
      trigger_in = 1'b0;
      invert_trigger = 1'b0;
      cfg_delay = '0;
      cfg_width = '0;
      cfg_gap = '0;
      cfg_count = '0;
      cfg_vstart = '0;
      test_reset();
      test_basic();
      test_pulse_train();
      test_merge_count0();
      test_invert();
      test_abort();
      test_cfg_hold();
      test_rst_mid_gap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
